// File: rtl/fifo_mux_out_if.sv
// Handshake and status bundle between the mux stage,
// the output FIFO and its consumer.
interface fifo_mux_out_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow_err;

  modport master (
    output data_in,
    output valid_in,
    output pop,
    input  data_out,
    input  valid_out,
    input  count,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  overflow_err
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  pop,
    output data_out,
    output valid_out,
    output count,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output overflow_err
  );
endinterface

// File: rtl/fifo_mux_out.sv
// Output FIFO behind the 2:1 mux: registered read port,
// level flags from the registered count, sticky overflow.
module fifo_mux_out #(
  parameter int DATA_WIDTH      = 4,
  parameter int DEPTH           = 4,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input logic           clk,
  input logic           reset_L,
  fifo_mux_out_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // A pop on a full FIFO frees the slot the push needs.
  assign do_pop  = bus.pop && !empty;
  assign do_push = bus.valid_in && (!full || bus.pop);

  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= CW'(ALMOST_FULL_TH));
  assign bus.almost_empty = (cnt <= CW'(ALMOST_EMPTY_TH));

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      cnt              <= '0;
      bus.data_out     <= '0;
      bus.valid_out    <= 1'b0;
      bus.overflow_err <= 1'b0;
    end else begin
      bus.valid_out <= do_pop;
      if (do_pop) begin
        bus.data_out <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + AW'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (bus.valid_in && !do_push)
        bus.overflow_err <= 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_mux_out.sv
// Directed bench for fifo_mux_out: fill/drain, overflow,
// full push+pop, empty pop, wrap and async reset.
module tb_fifo_mux_out;
  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  fifo_mux_out_if #(.DATA_WIDTH(4), .DEPTH(4)) bus ();

  fifo_mux_out #(
    .DATA_WIDTH     (4),
    .DEPTH          (4),
    .ALMOST_FULL_TH (3),
    .ALMOST_EMPTY_TH(1)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    bus.pop      = 1'b0;
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic pop_chk(input string tag,
                         input logic [3:0] w,
                         input int c);
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    chk({tag, "_do"}, 32'(bus.data_out), 32'(w));
    chk({tag, "_vo"}, 32'(bus.valid_out), 32'd1);
    chk({tag, "_cnt"}, 32'(bus.count), 32'(c));
  endtask

  task automatic pulse_reset();
    #2 reset_L = 1'b0;
    #2 reset_L = 1'b1;
  endtask

  logic [3:0] fill_a [4] = '{4'h1, 4'h2, 4'h3, 4'h0};
  logic [3:0] fill_b [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
  logic [3:0] fill_c [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
  logic [3:0] drain_c[4] = '{4'h9, 4'hA, 4'hB, 4'h5};

  initial begin
    checks       = 0;
    errors       = 0;
    reset_L      = 1'b0;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.pop      = 1'b0;

    // 1: reset
    step();
    step();
    chk("rst_cnt", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_vo", 32'(bus.valid_out), 32'd0);
    chk("rst_do", 32'(bus.data_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    reset_L = 1'b1;

    // 2: fill and drain
    for (int i = 0; i < 4; i++) begin
      push(fill_a[i]);
      chk("fill_cnt", 32'(bus.count), 32'(i + 1));
      chk("fill_full", 32'(bus.full), 32'(i == 3));
      chk("fill_af", 32'(bus.almost_full), 32'(i >= 2));
      chk("fill_ae", 32'(bus.almost_empty), 32'(i == 0));
    end
    for (int i = 0; i < 4; i++)
      pop_chk("drain", fill_a[i], 3 - i);
    step();
    chk("idle_vo", 32'(bus.valid_out), 32'd0);
    chk("idle_do", 32'(bus.data_out), 32'd0);
    chk("idle_empty", 32'(bus.empty), 32'd1);

    // 3: overflow
    for (int i = 0; i < 4; i++) push(fill_b[i]);
    push(4'hF);
    chk("ovf_cnt", 32'(bus.count), 32'd4);
    chk("ovf_err", 32'(bus.overflow_err), 32'd1);
    step();
    chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
    for (int i = 0; i < 4; i++)
      pop_chk("ovf_drain", fill_b[i], 3 - i);
    chk("ovf_end_empty", 32'(bus.empty), 32'd1);
    chk("ovf_end_err", 32'(bus.overflow_err), 32'd1);

    // 4: push+pop while full
    pulse_reset();
    chk("rst2_ovf", 32'(bus.overflow_err), 32'd0);
    step();
    for (int i = 0; i < 4; i++) push(fill_c[i]);
    bus.data_in  = 4'h5;
    bus.valid_in = 1'b1;
    bus.pop      = 1'b1;
    step();
    bus.valid_in = 1'b0;
    bus.pop      = 1'b0;
    chk("fpp_do", 32'(bus.data_out), 32'h8);
    chk("fpp_vo", 32'(bus.valid_out), 32'd1);
    chk("fpp_cnt", 32'(bus.count), 32'd4);
    chk("fpp_ovf", 32'(bus.overflow_err), 32'd0);
    for (int i = 0; i < 4; i++)
      pop_chk("fpp_drain", drain_c[i], 3 - i);

    // 5: empty pop, then alternating traffic across wrap
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    chk("epop_vo", 32'(bus.valid_out), 32'd0);
    chk("epop_do", 32'(bus.data_out), 32'h5);
    chk("epop_cnt", 32'(bus.count), 32'd0);
    chk("epop_ovf", 32'(bus.overflow_err), 32'd0);
    for (int w = 0; w < 10; w++) begin
      push(4'(w));
      chk("alt_cnt", 32'(bus.count), 32'd1);
      pop_chk("alt", 4'(w), 0);
    end

    // 6: async reset between edges
    for (int i = 0; i < 4; i++) push(4'(i + 1));
    pop_chk("pre_rst", 4'h1, 3);
    #2 reset_L = 1'b0;
    #1;
    chk("arst_cnt", 32'(bus.count), 32'd0);
    chk("arst_vo", 32'(bus.valid_out), 32'd0);
    chk("arst_do", 32'(bus.data_out), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    step();
    reset_L = 1'b1;
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    chk("post_rst_vo", 32'(bus.valid_out), 32'd0);
    chk("post_rst_cnt", 32'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_mux_out.md
Name: fifo_mux_out

Overview:
- Synchronous buffer directly downstream of the 2:1 4-bit mux. Captures each mux output word flagged valid, holds up to DEPTH words, and releases them in order on a pop request.
- Decouples the mux, which can produce a word every cycle, from a consumer that may stall.
- Reports fill level, threshold flags and a sticky overflow error for the verification bench.

Parameters:
DATA_WIDTH, 4, width of each stored word; matches the mux data path
DEPTH, 4, number of entries; must be a power of 2, minimum 2
ALMOST_FULL_TH, 3, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 1, almost_empty asserts when count <= this value

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset_L  input  1  asynchronous, active-low reset
data_in  input  DATA_WIDTH  word from the mux (data_out of the mux stage)
valid_in  input  1  push request; mux valid_out drives it
pop  input  1  consumer read request
data_out  output  DATA_WIDTH  registered word read from the FIFO
valid_out  output  1  data_out holds a word popped on the previous edge
count  output  log2(DEPTH)+1  current number of stored words, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_TH
almost_empty  output  1  count <= ALMOST_EMPTY_TH
overflow_err  output  1  sticky; a push was dropped

Behaviour:
- Reset (reset_L low, asynchronous, takes effect at any time including mid-operation):
  - Read pointer, write pointer and count = 0.
  - data_out = 0, valid_out = 0, overflow_err = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage contents are don't-care; outputs must not expose them.
  - While reset_L is low, push and pop are ignored. Operation resumes on the first rising edge after reset_L goes high.
- Storage and flags:
  - Storage is an array of DEPTH entries.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - full, empty, almost_full and almost_empty are combinational functions of the registered count only; they must not depend on the current push or pop.
- Push accepted when valid_in = 1 and (full = 0, or pop = 1 in the same cycle):
  - mem[wr_ptr] <= data_in, wr_ptr + 1.
  - A push while full with no pop is dropped: storage and count unchanged, overflow_err <= 1 until reset.
- Pop accepted when pop = 1 and empty = 0:
  - data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr + 1.
  - Read latency is 1 cycle: the word appears on the edge that accepts the pop.
- Pop with empty = 1 is ignored: valid_out <= 0, data_out holds its last value, no error. No fall-through: a word pushed into an empty FIFO can be popped no earlier than the following cycle.
- With no accepted pop on an edge: valid_out <= 0 and data_out holds.
- Simultaneous push and pop:
  - Both accepted and count unchanged, when empty = 0. When full, the push is accepted because the pop frees a slot, so no overflow.
  - When empty = 1, only the push is accepted and count goes to 1.
- Count update per edge: +1 for push only, -1 for pop only, 0 for both or neither.
- Ordering: strict FIFO; words exit in push order across pointer wrap.

Test Plan:
1. Reset then idle: hold reset_L = 0 for 2 edges, release -> count = 0, empty = 1, almost_empty = 1, valid_out = 0, data_out = 0, overflow_err = 0.
2. Fill and drain: push 1, 2, 3, 0 on 4 consecutive edges, then pop 4 edges ->
   - count steps 1..4, almost_full at count 3, full at 4.
   - data_out = 1, 2, 3, 0 with valid_out = 1 each cycle.
   - Ends empty = 1.
3. Overflow: with count = 4, push 0xF with no pop -> word dropped, count stays 4, overflow_err = 1 and stays 1. Later pops return the original 4 words only.
4. Simultaneous push/pop when full: count = 4, push 5 together with pop -> data_out = oldest word, count stays 4, overflow_err stays 0. The word 5 emerges last after 4 more pops.
5. Empty pop and wrap: pop on an empty FIFO -> valid_out = 0, no state change. Then push and pop alternately 10 words 0..9 -> pointers wrap twice and words exit in order 0..9.
6. Async reset mid-run: with count = 3, drop reset_L between clock edges -> count, valid_out and data_out clear immediately without waiting for clk. After release, a pop returns valid_out = 0.
